// File: rtl/io_block_reg.sv
// io_block_reg: N_IO-pad perimeter IO block with serial config chain (clk, reset, config_in/en/out/valid, data_in/out/oe, cx_in/out)
module io_block_reg #(
   parameter int N_IO        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CFG_PER_IO  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            config_in,
   input  logic            config_en,
   output logic            config_out,
   output logic            config_valid,
   input  logic [N_IO-1:0] data_in,
   input  logic [N_IO-1:0] cx_in,
   output logic [N_IO-1:0] data_out,
   output logic [N_IO-1:0] data_oe,
   output logic [N_IO-1:0] cx_out
);
   localparam int CW   = N_IO * CFG_PER_IO;
   localparam int CNTW = $clog2(CW + 1);
   logic [CW-1:0]   cfg;
   logic [CNTW-1:0] cnt;
   logic            en_q;
   logic [N_IO-1:0] sync [SYNC_STAGES];
   logic [N_IO-1:0] out_q;
   logic [N_IO-1:0] in_en, out_en, in_reg, out_reg;
   logic            g;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg   <= '0;
         cnt   <= '0;
         en_q  <= 1'b0;
         out_q <= '0;
         for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
      end else begin
         en_q  <= config_en;
         out_q <= cx_in;
         sync[0] <= data_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
         if (config_en) begin
            cfg <= {cfg[CW-2:0], config_in};
            cnt <= !en_q ? CNTW'(1) : (cnt == CNTW'(CW)) ? cnt : cnt + CNTW'(1);
         end
      end
   end
   for (genvar i = 0; i < N_IO; i++) begin : g_pad
      assign in_en[i]   = cfg[CFG_PER_IO*i];
      assign out_en[i]  = cfg[CFG_PER_IO*i+1];
      assign in_reg[i]  = cfg[CFG_PER_IO*i+2];
      assign out_reg[i] = cfg[CFG_PER_IO*i+3];
   end
   assign config_out   = cfg[CW-1];
   assign config_valid = (cnt == CNTW'(CW)) && !config_en;
   assign g            = config_valid;
   assign cx_out       = in_en & {N_IO{g}} & ((in_reg & sync[SYNC_STAGES-1]) | (~in_reg & data_in));
   assign data_oe      = out_en & {N_IO{g}};
   assign data_out     = data_oe & ((out_reg & out_q) | (~out_reg & cx_in));
endmodule

// File: doc/io_block_reg.md
Name: io_block_reg

Overview:
- Parametrised successor to the fabric IO block: N_IO pads, each with its own 4-bit config field loaded through a serial config chain.
- Adds per-pad direction enables, an optional registered/synchronised input path and an optional registered output path.
- Tracks chain-load completion and holds all fabric- and pad-side outputs at 0 until a full config image has been shifted in.
- Sits on the array perimeter; its config_in/config_out daisy-chain with neighbouring blocks.

Parameters:
- N_IO, 4, number of pads/channels.
- SYNC_STAGES, 2, flops in the registered input path (>=1).
- CFG_PER_IO, 4, config bits per pad (fixed at 4; exposed for chain-length arithmetic only).

Ports:
- clk  input  1  single clock for config shifting and datapath registers
- reset  input  1  asynchronous, active-high
- config_in  input  1  serial config data
- config_en  input  1  shift enable
- config_out  output  1  serial chain output to next block
- config_valid  output  1  full image loaded and config_en low
- data_in  input  N_IO  pad-side input
- cx_in  input  N_IO  fabric-side input
- data_out  output  N_IO  pad-side output
- data_oe  output  N_IO  pad output enable
- cx_out  output  N_IO  fabric-side output

Behaviour:
- CW = N_IO*CFG_PER_IO.
- Config register cfg[CW-1:0]: on clk rise with config_en=1, cfg <= {cfg[CW-2:0], config_in}.
- config_out = cfg[CW-1], combinational from the register.
- Pad i uses cfg[4i+3:4i] = {out_reg, in_reg, out_en, in_en} (bit 4i = in_en).
- Load counter cnt (clog2(CW+1) bits), saturating at CW:
  - a cycle with config_en=1 and previous config_en=0 sets cnt=1 (new session, this bit counted);
  - otherwise each config_en=1 cycle does cnt=min(cnt+1,CW).
- config_valid = (cnt==CW) && !config_en.
  - Fewer than CW bits in a session -> config_valid stays 0.
  - More than CW bits -> still valid; cfg holds the last CW bits.
- Gate g = config_valid. While g=0: cx_out=0, data_out=0, data_oe=0. Input/output pipeline flops keep clocking but their outputs are masked.
- Input path, pad i:
  - in_en=0 -> cx_out[i]=0.
  - in_reg=0 -> cx_out[i]=data_in[i], combinational.
  - in_reg=1 -> data_in[i] passes through a SYNC_STAGES flop chain; cx_out[i] changes SYNC_STAGES clk edges after data_in.
- Output path, pad i:
  - data_oe[i]=out_en & g.
  - out_reg=0 -> data_out[i]=cx_in[i]&data_oe[i].
  - out_reg=1 -> one flop; data_out updates one edge after cx_in.
  - data_out is 0 whenever data_oe=0.
- in_en and out_en may both be 1 (bidirectional loopback allowed); paths are independent.
- Reset (asynchronous, any time, including mid-load):
  - cfg=0, cnt=0, all pipeline flops 0;
  - immediately config_valid=0, config_out=0, cx_out=0, data_out=0, data_oe=0.
  - After reset release a complete reload is required.
- Reasserting config_en after a valid load drops config_valid on that same cycle; outputs are masked until the new session reaches CW bits and config_en deasserts.

Test Plan:
- Reset, then shift 16 bits (N_IO=4) giving cfg=16'h0003 (pad0 in_en=1, out_en=1, comb), drop config_en -> config_valid=1 next cycle; data_in[0]=1 gives cx_out[0]=1 same cycle; cx_in[0]=1 gives data_out[0]=1, data_oe=4'b0001; other pads 0.
- Shift only 15 bits then drop config_en -> config_valid=0; all outputs stay 0 under any data_in/cx_in.
- cfg=16'h0005 for pad0 (in_en=1, in_reg=1), SYNC_STAGES=2, pulse data_in[0] 0->1 at edge k -> cx_out[0] goes 1 at edge k+2, not earlier.
- cfg=16'h000A for pad0 (out_en=1, out_reg=1), toggle cx_in[0] -> data_out[0] follows one edge later; data_oe[0]=1 throughout.
- Shift 20 bits with pattern 0xF000_0 (first 4 ones) -> config_out emits those ones on shift cycles 17-20; config_valid=1 after deassert.
- Assert reset mid-session (after 8 bits) -> outputs and config_out go 0 immediately. Then a full 16-bit reload -> normal operation per first scenario.
